change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream stage of the vending machine selection logic. Accepts a change amount in cents after a completed sale or a cancel/reset and pays it out as physical coins, one coin per handshake with the coin-ejector mechanism. Coins are chosen greedily, largest first, and a coin type whose hopper reports empty is skipped. The block also publishes a running per-coin tally, which the coins-display path uses.

## Interface
Parameters:
- MAX_CHANGE, 500: largest accepted amount, in cents.
- ACK_TIMEOUT, 1023: cycles to wait in WAIT_ACK before declaring a fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- amount  in  9  change to pay, unsigned cents; captured with start.
- clear  in  1  leaves FAULT and returns to IDLE; ignored in other states.
- hopper_empty  in  4  per coin, bit 3 = dollar (100), bit 2 = quarter (25), bit 1 = dime (10), bit 0 = nickel (5).
- eject_ack  in  1  pulse from the mechanism confirming the coin was dispensed.
- eject  out  4  one-hot, one-cycle pulse; same bit order as hopper_empty.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the payout is complete.
- err  out  1  one-cycle pulse when an amount is rejected.
- fault  out  1  level; high while in FAULT.
- remaining  out  9  cents still owed.
- tally  out  28  {n_dollar, n_quarter, n_dime, n_nickel}, 7 bits each; coins dispensed in the current or most recent payout.

## Operation
States: IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT.

**IDLE**
- On start, amount is checked.
- If amount > MAX_CHANGE, or amount is not a multiple of 5:
  - pulse err next cycle;
  - stay IDLE;
  - tally and remaining are unchanged.
- Otherwise:
  - remaining <= amount;
  - tally <= 0;
  - go to SELECT.
- amount = 0 is valid. It reaches DONE with no ejects.

**SELECT**
- If remaining = 0, go to DONE.
- Otherwise pick the highest-valued coin c where value(c) <= remaining and hopper_empty[c] = 0. Then latch c and go to EJECT.
- If no such coin exists, go to FAULT. remaining is held so it shows the unpaid cents.

**EJECT**
- eject[c] = 1 for exactly this cycle.
- Timeout counter is cleared.
- Go to WAIT_ACK.
- eject_ack is ignored in this state.

**WAIT_ACK**
- On eject_ack:
  - remaining -= value(c);
  - the tally field for c increments, saturating at 127;
  - go to SELECT.
- If the counter reaches ACK_TIMEOUT without an ack, go to FAULT. remaining is not decremented.

**DONE**
- done = 1 for one cycle, then go to IDLE.

**FAULT**
- fault = 1.
- Stays here until clear, then goes to IDLE. remaining and tally are held.

**General rules**
- start while busy is ignored; it is not queued.
- hopper_empty is sampled in SELECT only. A hopper that empties mid-handshake does not abort the current coin.
- Width rule: remaining never underflows, because a coin is only chosen when value(c) <= remaining.

## Timing
Reset (rst_n low, asynchronous):
- state = IDLE;
- eject = 0, busy = 0, done = 0, err = 0, fault = 0;
- remaining = 0, tally = 0.

Reset asserted mid-payout aborts immediately. Coins already ejected are not reported.

Cycle sequence, with start sampled at cycle 0:
- cycle 1: SELECT, busy = 1.
- cycle 2: EJECT, eject pulse.
- cycle 3 onward: WAIT_ACK.

Each coin costs 2 + (cycles until ack) cycles, minimum 3. An ack in the first WAIT_ACK cycle gives SELECT in the following cycle.

After the final ack:
- SELECT follows (1 cycle), then DONE, where done is high.
- IDLE follows on the next cycle, with busy low.

err comes 1 cycle after a rejected start.

Timeout: FAULT is entered ACK_TIMEOUT + 1 cycles after the eject pulse.

All outputs are registered.

## Test plan
- **Greedy payout.** amount = 40, ack on the first WAIT_ACK cycle.
  - eject sequence 0100, 0010, 0001;
  - tally = {0, 1, 1, 1};
  - done exactly once;
  - 11 cycles from start to done.
- **Full range.** amount = 500, all hoppers full → 5 dollar ejects, tally n_dollar = 5, remaining = 0 at done.
- **Empty-hopper fallback.**
  - quarter hopper empty, amount = 30 → dime ×3, n_dime = 3.
  - Dime and nickel also empty, amount = 30 → FAULT with remaining = 30.
  - clear → IDLE.
- **Rejects.** amount = 7 and amount = 505 each give an err pulse, no eject, busy stays 0; amount = 0 gives done with no eject.
- **Timeout and reset.**
  - amount = 25, ack withheld → FAULT, remaining = 25.
  - rst_n low during a second payout's WAIT_ACK → all outputs return to reset values asynchronously.
- **Start while busy.** A second start mid-payout is ignored; the tally reflects only the first amount.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout, one coin per eject/ack handshake.
// Publishes remaining cents and a per-coin tally of the current payout.
module change_dispenser #(
  parameter int unsigned MAX_CHANGE  = 500,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  amount,
  input  logic        clear,
  input  logic [3:0]  hopper_empty,
  input  logic        eject_ack,
  output logic [3:0]  eject,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        fault,
  output logic [8:0]  remaining,
  output logic [27:0] tally
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SELECT   = 3'd1;
  localparam logic [2:0] EJECT    = 3'd2;
  localparam logic [2:0] WAIT_ACK = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [2:0] FAULT    = 3'd5;

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [8:0] MAX_C = 9'(MAX_CHANGE);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [8:0]      rem_q, rem_d;
  logic [3:0][6:0] tally_q, tally_d;
  logic [1:0]      coin_q, coin_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [3:0]      eject_q, eject_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            fault_q, fault_d;
  logic            amt_ok;

  function automatic logic [8:0] coin_val(input logic [1:0] c);
    logic [8:0] v;
    unique case (c)
      2'd3:    v = 9'd100;
      2'd2:    v = 9'd25;
      2'd1:    v = 9'd10;
      default: v = 9'd5;
    endcase
    return v;
  endfunction

  assign amt_ok = (amount <= MAX_C) && ((amount % 9'd5) == 9'd0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tally_d = tally_q;
    coin_d  = coin_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (amt_ok) begin
            rem_d   = amount;
            tally_d = '0;
            state_d = SELECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SELECT: begin
        // largest coin that fits and whose hopper still has stock
        if (rem_q == 9'd0) begin
          state_d = DONE;
        end else if (rem_q >= 9'd100 && !hopper_empty[3]) begin
          coin_d  = 2'd3;
          state_d = EJECT;
        end else if (rem_q >= 9'd25 && !hopper_empty[2]) begin
          coin_d  = 2'd2;
          state_d = EJECT;
        end else if (rem_q >= 9'd10 && !hopper_empty[1]) begin
          coin_d  = 2'd1;
          state_d = EJECT;
        end else if (!hopper_empty[0]) begin
          coin_d  = 2'd0;
          state_d = EJECT;
        end else begin
          state_d = FAULT;
        end
      end
      EJECT: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (eject_ack) begin
          rem_d = rem_q - coin_val(coin_q);
          if (tally_q[coin_q] != 7'd127) begin
            tally_d[coin_q] = tally_q[coin_q] + 7'd1;
          end
          state_d = SELECT;
        end else if (cnt_q == TO_LAST) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      FAULT: begin
        if (clear) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are registered from the next state
  always_comb begin
    eject_d = (state_d == EJECT) ? (4'b0001 << coin_d) : 4'b0000;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tally_q <= '0;
      coin_q  <= '0;
      cnt_q   <= '0;
      eject_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tally_q <= tally_d;
      coin_q  <= coin_d;
      cnt_q   <= cnt_d;
      eject_q <= eject_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

  assign eject     = eject_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign fault     = fault_q;
  assign remaining = rem_q;
  assign tally     = tally_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: constant vector table, hand sequences
// and random payouts against an arithmetic greedy model.
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  amount;
  logic        clear;
  logic [3:0]  hopper_empty;
  logic        eject_ack;
  logic [3:0]  eject;
  logic        busy;
  logic        done;
  logic        err;
  logic        fault;
  logic [8:0]  remaining;
  logic [27:0] tally;

  change_dispenser dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amount(amount),
    .clear(clear), .hopper_empty(hopper_empty),
    .eject_ack(eject_ack), .eject(eject), .busy(busy),
    .done(done), .err(err), .fault(fault),
    .remaining(remaining), .tally(tally)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          amt;
    logic [3:0]  he;
    bit          e_err;
    bit          e_fault;
    int          e_rem;
    logic [27:0] e_tally;
    int          e_n;
    logic [11:0] e_seq;
    int          e_cyc;
  } row_t;

  row_t tbl[9];

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] ej_q[$];
  logic [3:0] exp_ej[$];
  bit o_err, o_fault;
  int o_cyc, o_sumlat, o_done_n;

  int m_rem;
  int m_cnt[4];
  bit m_err, m_fault;

  task automatic chk(input string nm, input integer got,
                     input integer exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // greedy reference: coin values and hoppers, plain arithmetic
  task automatic model(input int amt, input logic [3:0] he);
    int vals[4] = '{5, 10, 25, 100};
    int r;
    int found;
    exp_ej.delete();
    m_fault = 0;
    m_err = (amt > 500) || (amt % 5 != 0);
    if (m_err) return;
    r = amt;
    for (int c = 0; c < 4; c++) m_cnt[c] = 0;
    while (r > 0) begin
      found = -1;
      for (int c = 3; c >= 0; c--) begin
        if (found < 0 && !he[c] && vals[c] <= r) found = c;
      end
      if (found < 0) begin
        m_fault = 1;
        break;
      end
      r -= vals[found];
      m_cnt[found]++;
      exp_ej.push_back(4'b0001 << found);
    end
    m_rem = r;
  endtask

  task automatic run(input int amt, input logic [3:0] he,
                     input bit withhold, input int s2_cyc,
                     input int s2_amt, input bit rand_lat);
    int aw = 0;
    int cyc;
    int lat;
    bit fin = 0;
    ej_q.delete();
    o_err = 0; o_fault = 0; o_cyc = -1;
    o_sumlat = 0; o_done_n = 0;
    hopper_empty = he;
    amount = 9'(amt);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 3000) begin
      eject_ack = 1'b0;
      start = (cyc == s2_cyc);
      if (cyc == s2_cyc) amount = 9'(s2_amt);
      if (done) begin
        o_done_n++; o_cyc = cyc; fin = 1;
      end
      if (err) begin
        o_err = 1; o_cyc = cyc; fin = 1;
      end
      if (fault) begin
        o_fault = 1; o_cyc = cyc; fin = 1;
      end
      if (eject != 4'b0) begin
        chk("eject_onehot", $countones(eject), 1);
        ej_q.push_back(eject);
        lat = rand_lat ? int'($urandom_range(0, 3)) : 0;
        o_sumlat += lat;
        aw = withhold ? 0 : lat + 1;
      end else if (aw > 0) begin
        aw--;
        if (aw == 0) eject_ack = 1'b1;
      end
      if (!fin) begin
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    eject_ack = 1'b0;
    if (!fin) chk("payout_finished_in_budget", 0, 1);
  endtask

  task automatic verify(input string tag, input bit e_err,
                        input bit e_fault, input int e_rem,
                        input logic [27:0] e_tally, input int e_n,
                        input int e_cyc);
    chk({tag, " err"}, o_err, e_err);
    chk({tag, " fault"}, o_fault, e_fault);
    chk({tag, " remaining"}, remaining, e_rem);
    chk({tag, " tally"}, tally, e_tally);
    chk({tag, " n_ejects"}, ej_q.size(), e_n);
    for (int i = 0; i < exp_ej.size() && i < ej_q.size(); i++)
      chk({tag, " eject_seq"}, ej_q[i], exp_ej[i]);
    chk({tag, " cycles"}, o_cyc, e_cyc);
    if (e_err) begin
      chk({tag, " busy_after_err"}, busy, 0);
      tick();
      chk({tag, " err_pulse_len"}, err, 0);
    end else if (e_fault) begin
      chk({tag, " busy_in_fault"}, busy, 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk({tag, " busy_after_clear"}, busy, 0);
      chk({tag, " fault_after_clear"}, fault, 0);
    end else begin
      chk({tag, " done_once"}, o_done_n, 1);
      tick();
      chk({tag, " done_pulse_len"}, done, 0);
      chk({tag, " busy_after_done"}, busy, 0);
    end
  endtask

  initial begin
    logic [27:0] et;
    int amt;
    logic [3:0] he;
    rst_n = 1'b0; start = 1'b0; amount = '0; clear = 1'b0;
    hopper_empty = '0; eject_ack = 1'b0;

    tbl[0] = '{40, 4'h0, 0, 0, 0, {7'd0, 7'd1, 7'd1, 7'd1}, 3,
               12'b0100_0010_0001, 11};
    tbl[1] = '{500, 4'h0, 0, 0, 0, {7'd5, 7'd0, 7'd0, 7'd0}, 5,
               12'b1000_1000_1000, 17};
    tbl[2] = '{30, 4'h4, 0, 0, 0, {7'd0, 7'd0, 7'd3, 7'd0}, 3,
               12'b0010_0010_0010, 11};
    tbl[3] = '{30, 4'h7, 0, 1, 30, 28'd0, 0, 12'd0, 2};
    tbl[4] = '{7, 4'h0, 1, 0, 30, 28'd0, 0, 12'd0, 1};
    tbl[5] = '{505, 4'h0, 1, 0, 30, 28'd0, 0, 12'd0, 1};
    tbl[6] = '{0, 4'h0, 0, 0, 0, 28'd0, 0, 12'd0, 2};
    tbl[7] = '{95, 4'h0, 0, 0, 0, {7'd0, 7'd3, 7'd2, 7'd0}, 5,
               12'b0100_0100_0100, 17};
    tbl[8] = '{15, 4'h2, 0, 0, 0, {7'd0, 7'd0, 7'd0, 7'd3}, 3,
               12'b0001_0001_0001, 11};

    #12;
    chk("reset busy", busy, 0);
    chk("reset eject", eject, 0);
    chk("reset fault", fault, 0);
    chk("reset remaining", remaining, 0);
    chk("reset tally", tally, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      exp_ej.delete();
      for (int k = 0; k < 3 && k < tbl[i].e_n; k++)
        exp_ej.push_back(tbl[i].e_seq[11-4*k -: 4]);
      run(tbl[i].amt, tbl[i].he, 0, -1, 0, 0);
      verify($sformatf("row%0d", i), tbl[i].e_err, tbl[i].e_fault,
             tbl[i].e_rem, tbl[i].e_tally, tbl[i].e_n, tbl[i].e_cyc);
    end

    // second start mid-payout is dropped
    exp_ej.delete();
    exp_ej.push_back(4'b0100);
    exp_ej.push_back(4'b0010);
    exp_ej.push_back(4'b0001);
    run(40, 4'h0, 0, 4, 100, 0);
    verify("busy_start", 0, 0, 0, {7'd0, 7'd1, 7'd1, 7'd1}, 3, 11);

    // ack withheld: fault after ACK_TIMEOUT+1 cycles past the eject
    exp_ej.delete();
    exp_ej.push_back(4'b0100);
    run(25, 4'h0, 1, -1, 0, 0);
    verify("timeout", 0, 1, 25, 28'd0, 1, 1026);

    // asynchronous reset in the middle of WAIT_ACK
    amount = 9'd25;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_reset busy", busy, 1);
    chk("pre_reset remaining", remaining, 25);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst busy", busy, 0);
    chk("async_rst outs", {eject, done, err, fault}, 0);
    chk("async_rst remaining", remaining, 0);
    chk("async_rst tally", tally, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_rem = 0;
    for (int c = 0; c < 4; c++) m_cnt[c] = 0;

    for (int it = 0; it < 40; it++) begin
      int pr;
      int pc[4];
      pr = m_rem;
      for (int c = 0; c < 4; c++) pc[c] = m_cnt[c];
      if ($urandom_range(0, 7) == 0) amt = int'($urandom_range(0, 511));
      else amt = 5 * int'($urandom_range(0, 100));
      he = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
      model(amt, he);
      if (m_err) begin
        m_rem = pr;
        for (int c = 0; c < 4; c++) m_cnt[c] = pc[c];
      end
      run(amt, he, 0, -1, 0, 1);
      et = {7'(m_cnt[3]), 7'(m_cnt[2]), 7'(m_cnt[1]), 7'(m_cnt[0])};
      verify($sformatf("rnd%0d amt=%0d he=%b", it, amt, he),
             m_err, m_fault, m_rem, et, exp_ej.size(),
             m_err ? 1 : 3 * exp_ej.size() + o_sumlat + 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
